muldiv_unit: RTL

//   Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, with HI/LO result registers.

---
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Handles MULT, MULTU, DIV and DIVU. Each operation takes one latch cycle,
// WIDTH iterations of an unsigned shift-add / restoring-divide core, and
// one fixup cycle that applies the sign and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a full double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             is_div_r;
    logic             neg_res_r;   // product / quotient must be negated
    logic             neg_rem_r;   // remainder must be negated (dividend sign)
    logic             dbz_r;
    logic [WIDTH-1:0] opb_r;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_r;    // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_r;    // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] orig_a_r;    // raw dividend, returned in HI on divide by zero

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   mul_add_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    // Operand sign detection and magnitude extraction for the launch edge.
    always_comb begin
        a_neg_s = ~op[0] & a[WIDTH-1];
        b_neg_s = ~op[0] & b[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = neg_w(a);
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = neg_w(b);
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration of the unsigned core, plus the sign fixup of the final result.
    always_comb begin
        mul_add_s   = {(WIDTH+1){1'b0}};
        mul_sum_s   = {(WIDTH+1){1'b0}};
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        step_hi_s   = acc_hi_r;
        step_lo_s   = acc_lo_r;
        prod_s      = {acc_hi_r, acc_lo_r};
        fix_hi_s    = acc_hi_r;
        fix_lo_s    = acc_lo_r;

        if (is_div_r) begin
            // Restoring divide: keep the subtraction only when it did not borrow.
            if (!div_diff_s[WIDTH]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply: conditional add, then shift the pair right.
            if (acc_lo_r[0]) begin
                mul_add_s = {1'b0, opb_r};
            end else begin
                mul_add_s = {(WIDTH+1){1'b0}};
            end
            mul_sum_s = {1'b0, acc_hi_r} + mul_add_s;
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end

        if (is_div_r) begin
            if (dbz_r) begin
                // Divide by zero bypasses the sign fixup entirely.
                fix_lo_s = {WIDTH{1'b1}};
                fix_hi_s = orig_a_r;
            end else begin
                if (neg_res_r) begin
                    fix_lo_s = neg_w(acc_lo_r);
                end else begin
                    fix_lo_s = acc_lo_r;
                end
                if (neg_rem_r) begin
                    fix_hi_s = neg_w(acc_hi_r);
                end else begin
                    fix_hi_s = acc_hi_r;
                end
            end
        end else begin
            if (neg_res_r) begin
                prod_s = neg_2w({acc_hi_r, acc_lo_r});
            end else begin
                prod_s = {acc_hi_r, acc_lo_r};
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with registered outputs and the HI/LO result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            is_div_r    <= 1'b0;
            neg_res_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            dbz_r       <= 1'b0;
            opb_r       <= {WIDTH{1'b0}};
            acc_hi_r    <= {WIDTH{1'b0}};
            acc_lo_r    <= {WIDTH{1'b0}};
            orig_a_r    <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hi_we) begin
                        hi <= wdata;
                    end
                    if (lo_we) begin
                        lo <= wdata;
                    end
                    if (start) begin
                        is_div_r  <= op[1];
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        dbz_r     <= op[1] & (b == {WIDTH{1'b0}});
                        opb_r     <= b_mag_s;
                        acc_hi_r  <= {WIDTH{1'b0}};
                        acc_lo_r  <= a_mag_s;
                        orig_a_r  <= a;
                        cnt_r     <= {CW{1'b0}};
                        busy      <= 1'b1;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi          <= fix_hi_s;
                    lo          <= fix_lo_s;
                    done        <= 1'b1;
                    div_by_zero <= dbz_r;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
